// File: rtl/sensor_cmd_scheduler.sv
// sensor_cmd_scheduler: validates request packets, runs shared single-wire sensor reads,
// formats 16-bit TX responses and round-robin polls continuously enabled channels.
module sensor_cmd_scheduler #(
  parameter int N_ADDR         = 32,
  parameter int SENSOR_TIMEOUT = 50_000_000,
  parameter int CONT_PERIOD    = 100_000_000,
  parameter int CNT_W          = 28
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_code,
  input  logic [7:0]        cmd_addr,
  output logic              sensor_start,
  output logic [7:0]        sensor_addr,
  input  logic              sensor_done,
  input  logic              sensor_error,
  input  logic [39:0]       sensor_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [15:0]       tx_data,
  output logic [N_ADDR-1:0] cont_temp_en,
  output logic [N_ADDR-1:0] cont_hum_en
);
  localparam int NS = 2 * N_ADDR;
  localparam int SW = $clog2(NS);
  localparam int AW = $clog2(N_ADDR);
  localparam logic [8:0] ADDR_LIM = 9'(N_ADDR);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(SENSOR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(CONT_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, DECODE, SENSOR_REQ, SENSOR_WAIT, BUILD, TX_HOLD} state_t;

  state_t state_q, state_d;
  logic [7:0] code_q, code_d, addr_q, addr_d, temp_q, temp_d, hum_q, hum_d;
  logic src_q, src_d, chan_q, chan_d, fault_q, fault_d, tick_q, tick_d;
  logic [SW-1:0] slot_q, slot_d, rr_q, rr_d, pick, s;
  logic [CNT_W-1:0] wait_q, wait_d, per_q, per_d;
  logic [15:0] tx_q, tx_d;
  logic [N_ADDR-1:0] ten_q, ten_d, hen_q, hen_d;
  logic [NS-1:0] slots;
  logic [AW-1:0] ai;
  logic found, hit, bad_addr, any_en, take, unused_ok;

  // slot 2a is temperature of address a, slot 2a+1 its humidity
  for (genvar g = 0; g < N_ADDR; g++) begin : g_slot
    assign slots[2*g+1:2*g] = {hen_q[g], ten_q[g]};
  end

  assign ai = addr_q[AW-1:0];
  assign hit = chan_q ? hen_q[ai] : ten_q[ai];
  assign bad_addr = {1'b0, addr_q} >= ADDR_LIM;
  assign any_en = |{ten_q, hen_q};
  assign take = (state_q == IDLE) && !cmd_valid && tick_q && found;
  assign unused_ok = ^{sensor_data[31:24], sensor_data[15:0]};

  // descending scan so the nearest enabled slot after rr_q wins
  always_comb begin
    found = 1'b0;
    pick = '0;
    s = '0;
    for (int i = NS; i >= 1; i--) begin
      s = SW'((int'(rr_q) + i) % NS);
      if (slots[s]) begin
        found = 1'b1;
        pick = s;
      end
    end
  end

  always_comb begin
    per_d = '0;
    tick_d = 1'b0;
    if (any_en) begin
      per_d = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
      tick_d = (per_q == PER_LAST) || (tick_q && !take);
    end
  end

  always_comb begin
    state_d = state_q;
    code_d = code_q;
    addr_d = addr_q;
    src_d = src_q;
    chan_d = chan_q;
    slot_d = slot_q;
    rr_d = rr_q;
    fault_d = fault_q;
    temp_d = temp_q;
    hum_d = hum_q;
    wait_d = wait_q;
    tx_d = tx_q;
    ten_d = ten_q;
    hen_d = hen_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          code_d = cmd_code;
          addr_d = cmd_addr;
          chan_d = cmd_code[0];
          src_d = 1'b0;
          state_d = DECODE;
        end else if (take) begin
          addr_d = 8'(pick >> 1);
          chan_d = pick[0];
          slot_d = pick;
          src_d = 1'b1;
          state_d = SENSOR_REQ;
        end
      end
      DECODE: begin
        state_d = TX_HOLD;
        if (code_q == 8'd0 || code_q > 8'd7) tx_d = 16'hCF00;
        else if (bad_addr) tx_d = 16'hEF00;
        else if (code_q[2:1] == 2'b11) begin
          tx_d = hit ? {7'b0000101, chan_q, addr_q} : {8'hDF, addr_q};
          if (hit && chan_q) hen_d[ai] = 1'b0;
          if (hit && !chan_q) ten_d[ai] = 1'b0;
        end else begin
          if (code_q[2] && chan_q) hen_d[ai] = 1'b1;
          if (code_q[2] && !chan_q) ten_d[ai] = 1'b1;
          state_d = SENSOR_REQ;
        end
      end
      SENSOR_REQ: begin
        wait_d = '0;
        fault_d = 1'b0;
        state_d = SENSOR_WAIT;
      end
      SENSOR_WAIT: begin
        if (sensor_done) begin
          fault_d = sensor_error;
          hum_d = sensor_data[39:32];
          temp_d = sensor_data[23:16];
          state_d = BUILD;
        end else if (wait_q == TO_LAST) begin
          fault_d = 1'b1;
          state_d = BUILD;
        end else wait_d = wait_q + 1'b1;
      end
      BUILD: begin
        state_d = TX_HOLD;
        if (fault_q) begin
          tx_d = 16'h1F00;
          if ((src_q || code_q[2]) && chan_q) hen_d[ai] = 1'b0;
          if ((src_q || code_q[2]) && !chan_q) ten_d[ai] = 1'b0;
        end else if (src_q || code_q[2]) tx_d = chan_q ? {8'h0E, hum_q} : {8'h0D, temp_q};
        else tx_d = code_q[1] ? (code_q[0] ? {8'h08, hum_q} : {8'h09, temp_q}) : 16'h0700;
      end
      TX_HOLD: begin
        if (tx_ready) begin
          state_d = IDLE;
          if (src_q) rr_d = slot_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      code_q <= '0;
      addr_q <= '0;
      src_q <= 1'b0;
      chan_q <= 1'b0;
      slot_q <= '0;
      rr_q <= '0;
      fault_q <= 1'b0;
      temp_q <= '0;
      hum_q <= '0;
      wait_q <= '0;
      per_q <= '0;
      tick_q <= 1'b0;
      tx_q <= '0;
      ten_q <= '0;
      hen_q <= '0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      addr_q <= addr_d;
      src_q <= src_d;
      chan_q <= chan_d;
      slot_q <= slot_d;
      rr_q <= rr_d;
      fault_q <= fault_d;
      temp_q <= temp_d;
      hum_q <= hum_d;
      wait_q <= wait_d;
      per_q <= per_d;
      tick_q <= tick_d;
      tx_q <= tx_d;
      ten_q <= ten_d;
      hen_q <= hen_d;
    end
  end

  assign cmd_ready = reset_n && (state_q == IDLE);
  assign sensor_start = state_q == SENSOR_REQ;
  assign sensor_addr = addr_q;
  assign tx_valid = state_q == TX_HOLD;
  assign tx_data = tx_q;
  assign cont_temp_en = ten_q;
  assign cont_hum_en = hen_q;
endmodule
